// File: rtl/slot_bus_pkg.sv
// rtl/slot_bus_pkg.sv - shared event types and read FSM encoding for the slot bus front-end
package slot_bus_pkg;

    typedef enum logic [1:0] {
        EVT_CTRL    = 2'd0,
        EVT_WR      = 2'd1,
        EVT_RD_DONE = 2'd2
    } evt_type_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } rd_state_e;

    typedef struct packed {
        evt_type_e  etype;
        logic [7:0] data;
    } evt_t;

    // Byte returned to the monitor when the consumer never answers a read.
    localparam logic [7:0] RD_FILL_BYTE = 8'hFF;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/slot_bus_frontend_if.sv
// rtl/slot_bus_frontend_if.sv - slot bus, event stream and read handshake signal bundle
interface slot_bus_frontend_if;
    logic       slot_x;
    logic       clk_rw;
    logic       ax_d;
    logic       r_wx;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe_x;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_type;
    logic [7:0] evt_data;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_data;

    modport slave (
        input  slot_x, clk_rw, ax_d, r_wx, data_in, evt_ready, rd_ack, rd_data,
        output data_out, data_oe_x, evt_valid, evt_type, evt_data, rd_req
    );

    modport master (
        output slot_x, clk_rw, ax_d, r_wx, data_in, evt_ready, rd_ack, rd_data,
        input  data_out, data_oe_x, evt_valid, evt_type, evt_data, rd_req
    );
endinterface

// File: rtl/slot_sync_filter.sv
// rtl/slot_sync_filter.sv - 2-FF synchroniser followed by a run-length deglitch filter
module slot_sync_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic filt_o
);

    logic [1:0] sync_q;
    logic       filt_q, filt_d;
    logic [3:0] run_q, run_d;

    // Synchroniser resets to the idle (high) level so no run starts out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            run_q  <= 4'd0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        run_d  = 4'd0;
        if (sync_q[1] != filt_q) begin
            if (run_q == 4'(FILT_LEN - 1))
                filt_d = ~filt_q;
            else
                run_d = run_q + 4'd1;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/slot_bus_frontend.sv
// rtl/slot_bus_frontend.sv - slot bus capture, event queue and read handshake front-end
module slot_bus_frontend
    import slot_bus_pkg::*;
#(
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                 clk_20mhz,
    input  logic                 reset,
    slot_bus_frontend_if.slave   bus,
    output logic                 overflow,
    output logic                 rd_timeout
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = cnt_width(RD_TIMEOUT);

    logic slot_f, clk_f, ax_f, rw_f;
    logic clk_prev_q;
    logic clk_rise, clk_fall, slot_act;
    logic [7:0] din_s1_q, din_s2_q;

    slot_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_slot (
        .clk(clk_20mhz), .rst(reset), .async_i(bus.slot_x), .filt_o(slot_f));
    slot_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_clk (
        .clk(clk_20mhz), .rst(reset), .async_i(bus.clk_rw), .filt_o(clk_f));
    slot_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_ax (
        .clk(clk_20mhz), .rst(reset), .async_i(bus.ax_d), .filt_o(ax_f));
    slot_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_rw (
        .clk(clk_20mhz), .rst(reset), .async_i(bus.r_wx), .filt_o(rw_f));

    always_ff @(posedge clk_20mhz or posedge reset) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
            din_s1_q   <= 8'h00;
            din_s2_q   <= 8'h00;
        end else begin
            clk_prev_q <= clk_f;
            din_s1_q   <= bus.data_in;
            din_s2_q   <= din_s1_q;
        end
    end

    assign clk_rise = clk_f & ~clk_prev_q;
    assign clk_fall = ~clk_f & clk_prev_q;
    assign slot_act = ~slot_f;

    // ---------------- read FSM ----------------
    rd_state_e       state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            rd_timeout_q, to_set;
    logic            rd_push;

    always_ff @(posedge clk_20mhz or posedge reset) begin
        if (reset) begin
            state_q      <= RD_IDLE;
            tmr_q        <= '0;
            data_out_q   <= RD_FILL_BYTE;
            rd_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            data_out_q   <= data_out_d;
            rd_timeout_q <= rd_timeout_q | to_set;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        data_out_d = data_out_q;
        to_set     = 1'b0;
        rd_push    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (clk_fall && slot_act && ax_f && rw_f) begin
                    state_d = RD_WAIT;
                    tmr_d   = '0;
                end
            end
            RD_WAIT: begin
                // A new strobe before the data arrived means the monitor gave up.
                if (clk_rise) begin
                    state_d = RD_IDLE;
                    to_set  = 1'b1;
                end else if (bus.rd_ack) begin
                    data_out_d = bus.rd_data;
                    state_d    = RD_DRIVE;
                end else if (tmr_q == TW'(RD_TIMEOUT)) begin
                    data_out_d = RD_FILL_BYTE;
                    to_set     = 1'b1;
                    state_d    = RD_DRIVE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RD_DRIVE: begin
                if (!slot_act || !ax_f || !rw_f) begin
                    state_d = RD_IDLE;
                end else if (clk_rise) begin
                    rd_push = 1'b1;
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // rd_req is the first cycle of RD_WAIT, where the timer was just cleared.
    always_comb begin
        bus.rd_req    = (state_q == RD_WAIT) && (tmr_q == '0);
        bus.data_oe_x = (state_q != RD_DRIVE);
    end

    assign bus.data_out = data_out_q;
    assign rd_timeout   = rd_timeout_q;

    // ---------------- event FIFO ----------------
    evt_t          mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          overflow_q;
    logic          bus_push, push, push_acc, pop, full, empty;
    evt_t          push_evt;

    assign bus_push = clk_rise && slot_act && (!ax_f || !rw_f);
    assign push     = bus_push | rd_push;

    always_comb begin
        push_evt.data  = rd_push ? data_out_q : din_s2_q;
        push_evt.etype = rd_push ? EVT_RD_DONE : (ax_f ? EVT_WR : EVT_CTRL);
    end

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop      = !empty && bus.evt_ready;
    assign push_acc = push && (!full || pop);

    always_ff @(posedge clk_20mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_evt;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.evt_valid = !empty;
    assign bus.evt_type  = mem_q[rd_ptr_q[AW-1:0]].etype;
    assign bus.evt_data  = mem_q[rd_ptr_q[AW-1:0]].data;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_slot_bus_frontend.sv
// tb/tb_slot_bus_frontend.sv - directed self-checking bench for slot_bus_frontend
module tb_slot_bus_frontend;

    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0] t;
        logic [7:0] d;
    } exp_evt_t;

    logic clk = 1'b0;
    logic rst;
    logic ovf, rto;
    int   total = 0;
    int   bad   = 0;

    exp_evt_t   mq[$];
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_rd  = 8'hFF;

    slot_bus_frontend_if bus();

    slot_bus_frontend dut (
        .clk_20mhz (clk),
        .reset     (rst),
        .bus       (bus.slave),
        .overflow  (ovf),
        .rd_timeout(rto)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [1:0] t, input logic [7:0] d);
        exp_evt_t e;
        e.t = t;
        e.d = d;
        if (mq.size() < DEPTH) mq.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    // Consumer side: every accepted event must match the next expected one.
    initial begin
        exp_evt_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.evt_valid && bus.evt_ready) begin
                if (mq.size() == 0) begin
                    check("evt_unexpected", {22'd0, bus.evt_type, bus.evt_data}, 32'd0);
                end else begin
                    e = mq.pop_front();
                    check("evt_type", bus.evt_type, e.t);
                    check("evt_data", bus.evt_data, e.d);
                end
            end
            if (!rst && !bus.data_oe_x) check("data_out_drive", bus.data_out, exp_rd);
        end
    end

    task automatic bus_write(input logic ax, input logic [7:0] d, output int lat);
        bus.ax_d    = ax;
        bus.r_wx    = 1'b0;
        bus.data_in = d;
        exp_push(ax ? 2'd1 : 2'd0, d);
        repeat (6) tick();
        bus.clk_rw = 1'b0;
        repeat (6) tick();
        bus.clk_rw = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (lat < 0 && bus.evt_valid) lat = i;
        end
    endtask

    task automatic start_read(output int lat);
        bus.ax_d = 1'b1;
        bus.r_wx = 1'b1;
        repeat (6) tick();
        bus.clk_rw = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.rd_req) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic end_read(input logic [7:0] d);
        exp_push(2'd2, d);
        bus.clk_rw = 1'b1;
        repeat (10) tick();
        check("oe_released", bus.data_oe_x, 1'b1);
    endtask

    initial begin
        int lat;
        rst           = 1'b1;
        bus.slot_x    = 1'b1;
        bus.clk_rw    = 1'b1;
        bus.ax_d      = 1'b1;
        bus.r_wx      = 1'b1;
        bus.data_in   = 8'h00;
        bus.evt_ready = 1'b1;
        bus.rd_ack    = 1'b0;
        bus.rd_data   = 8'h00;
        repeat (3) tick();
        check("rst_data_out", bus.data_out, 8'hFF);
        check("rst_oe", bus.data_oe_x, 1'b1);
        check("rst_valid", bus.evt_valid, 1'b0);
        check("rst_type", bus.evt_type, 2'd0);
        check("rst_data", bus.evt_data, 8'h00);
        check("rst_rd_req", bus.rd_req, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_rto", rto, 1'b0);
        rst = 1'b0;
        repeat (2) tick();
        bus.slot_x = 1'b0;
        repeat (8) tick();

        // control/control/write sequence
        bus_write(1'b0, 8'h22, lat);
        check("evt_latency", lat, 6);
        bus_write(1'b0, 8'h25, lat);
        bus_write(1'b1, 8'hA0, lat);
        check("ovf_after_writes", ovf, 1'b0);

        // read answered 3 cycles after rd_req
        exp_rd = 8'h88;
        start_read(lat);
        check("rd_req_latency", lat, 6);
        tick();
        check("rd_req_pulse", bus.rd_req, 1'b0);
        repeat (2) tick();
        bus.rd_ack  = 1'b1;
        bus.rd_data = 8'h88;
        tick();
        bus.rd_ack  = 1'b0;
        bus.rd_data = 8'h00;
        check("ack_oe", bus.data_oe_x, 1'b0);
        check("ack_data_out", bus.data_out, 8'h88);
        repeat (4) tick();
        check("ack_oe_held", bus.data_oe_x, 1'b0);
        end_read(8'h88);
        check("rto_clean", rto, 1'b0);

        // unanswered read falls back to 0xFF
        exp_rd = 8'hFF;
        start_read(lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!bus.data_oe_x) begin
                lat = i;
                break;
            end
        end
        check("timeout_latency", lat, 17);
        check("timeout_data_out", bus.data_out, 8'hFF);
        check("timeout_flag", rto, 1'b1);
        end_read(8'hFF);

        // six writes into a stalled queue of four
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) bus_write(1'b1, 8'h31 + 8'(i), lat);
        check("full_valid", bus.evt_valid, 1'b1);
        check("overflow", ovf, exp_ovf);
        bus.evt_ready = 1'b1;
        repeat (8) tick();
        check("drained_valid", bus.evt_valid, 1'b0);
        check("drained_model", mq.size(), 0);

        // 2-cycle strobe glitch
        bus.evt_ready = 1'b0;
        bus.ax_d      = 1'b0;
        bus.r_wx      = 1'b0;
        bus.data_in   = 8'h5A;
        repeat (6) tick();
        bus.clk_rw = 1'b0;
        repeat (2) tick();
        bus.clk_rw = 1'b1;
        repeat (12) tick();
        check("glitch_no_evt", bus.evt_valid, 1'b0);
        bus.evt_ready = 1'b1;

        // reset while driving read data
        bus.evt_ready = 1'b0;
        bus_write(1'b0, 8'h77, lat);
        exp_rd = 8'h3C;
        start_read(lat);
        tick();
        bus.rd_ack  = 1'b1;
        bus.rd_data = 8'h3C;
        tick();
        bus.rd_ack = 1'b0;
        check("pre_rst_oe", bus.data_oe_x, 1'b0);
        check("pre_rst_valid", bus.evt_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_oe", bus.data_oe_x, 1'b1);
        check("async_rst_valid", bus.evt_valid, 1'b0);
        check("async_rst_ovf", ovf, 1'b0);
        check("async_rst_rto", rto, 1'b0);
        check("async_rst_data_out", bus.data_out, 8'hFF);
        mq.delete();
        exp_ovf       = 1'b0;
        bus.clk_rw    = 1'b1;
        bus.slot_x    = 1'b1;
        bus.evt_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        bus.slot_x = 1'b0;
        repeat (8) tick();
        bus_write(1'b0, 8'h99, lat);
        check("post_rst_latency", lat, 6);
        repeat (4) tick();
        check("final_model_empty", mq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
